serial_mmio_uart: RTL
=====================

// Module: serial_mmio_uart
// PURPOSE
//  Memory-mapped UART responder for the CPU data port at 0xBFD003F8 (data) and 0xBFD003FC (status).
//  The SRAM controller routes these addresses away from Base/Ext RAM; this block answers them.
//  Write to data pushes a byte to the TX FIFO; read of data pops the RX FIFO.
//  8N1 serialiser/deserialiser drives txd and samples rxd.
// PARAMETERS
//  CLK_FREQ    50000000  system clock in Hz
//  BAUD        9600      line rate; DIV = CLK_FREQ/BAUD (integer, truncated), 5208 at defaults
//  FIFO_DEPTH  4         entries per direction, power of two, >=2
// PORTS
//  clk          in   1   system clock, 50 MHz
//  rst          in   1   synchronous, active-high reset
//  mmio_addr_i  in   32  CPU data address
//  mmio_ce_i    in   1   access strobe; each cycle high with an address match is exactly one access
//  mmio_we_n_i  in   1   0 = write, 1 = read
//  mmio_data_i  in   32  write data; only [7:0] used
//  mmio_data_o  out  32  read data, combinational, valid in the same cycle
//  txd          out  1   serial out, idle high
//  rxd          in   1   serial in, asynchronous
// BEHAVIOUR
//  Reset: txd=1; both FIFOs empty; TX/RX FSMs IDLE; counters 0; mmio_data_o=0.
//  Decode: hit_dat = ce & addr==BFD003F8; hit_st = ce & addr==BFD003FC. Any other address: no effect, data_o=0.
//  Status read: data_o = {30'b0, rx_avail, tx_ready}.
//   tx_ready = TX FIFO not full; rx_avail = RX FIFO not empty.
//  Data read: data_o = {24'b0, rx_head}, or 0 when RX FIFO is empty. Pop at the clock edge ending that cycle.
//   A read when empty is a no-op.
//  Data write: push mmio_data_i[7:0] at the clock edge; a write when full is dropped silently.
//  Status write: ignored.
//  TX FSM IDLE->START->DATA->STOP->IDLE, each bit DIV cycles, LSB first.
//   IDLE pops the FIFO head when it is non-empty and drives txd=0 on the next cycle.
//   Back-to-back bytes leave no idle gap. txd=1 in IDLE and STOP.
//  RX: 2-flop synchroniser on rxd. FSM IDLE->START->DATA->STOP.
//   IDLE detects the falling edge of the synchronised rxd.
//   START waits DIV/2 cycles, then re-samples: if high, glitch, return to IDLE.
//   DATA samples every DIV cycles (mid-bit), 8 bits, LSB first.
//   STOP samples at mid-bit: high = push byte; low = framing error, byte discarded.
//   RX returns to IDLE after the stop sample, not at the end of the stop bit.
//  RX overrun: byte completes while RX FIFO is full -> byte dropped; FIFO contents unchanged.
//  Simultaneous events, same FIFO:
//   CPU pop and RX push on the same edge: both happen; count unchanged.
//   CPU push and TX pop on the same edge: both happen.
//   Push into a full FIFO with a simultaneous pop is accepted.
//  FIFO pointers are log2(FIFO_DEPTH)+1 bits; wrap is natural; full = MSBs differ and LSBs equal.
//  Reset mid-frame: txd goes high next cycle; any partial RX byte is lost.
// CONFIGURATION
//  SERIAL_LOOPBACK_EN defined: the RX synchroniser input is the internal txd, and the external rxd is ignored.
//   The txd pin still toggles.
//  SERIAL_LOOPBACK_EN undefined: RX samples the rxd pin.
// STRUCTURE
//  Shared header serial_defs.vh: SERIAL_DATA_ADDR, SERIAL_STAT_ADDR, STAT_TX_READY_BIT=0, STAT_RX_AVAIL_BIT=1.
//   The SRAM controller decode includes the same header.
//  Sub-module serial_fifo (WIDTH=8, DEPTH): sync FIFO with push/pop/full/empty/head.
//   Instantiated twice, once per direction.
//  TX and RX FSMs are inline in this module.
// TESTING (CLK_FREQ=50e6, BAUD=9600 unless noted; bench uses DIV=8 override for speed)
//  1 After rst: status read returns 0x00000001, data read returns 0x00000000, txd=1.
//  2 Write 0x55 to data: start bit within 2 cycles; txd low, then 1,0,1,0,1,0,1,0, then high.
//    Each bit is DIV cycles.
//  3 Drive 8N1 frame 0xA5 on rxd: after the stop mid-bit, status=0x3. Data read returns 0xA5.
//    The next status read returns 0x1.
//  4 Write 5 bytes 0x01..0x05 back-to-back with DEPTH=4 while TX is busy: tx_ready drops to 0 once full.
//    The overflow write is dropped. txd emits exactly the bytes accepted, with no idle gap between frames.
//  5 rxd pulse low for DIV/4 cycles: no byte pushed. Frame with stop bit=0: no byte pushed, status=0x1.
//  6 With SERIAL_LOOPBACK_EN: write 0x3C, wait 10*DIV cycles, read data -> 0x3C.
//    Assert rst mid-frame: txd=1 next cycle, status=0x1.

Source files
------------

// File: rtl/serial_mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART and the SRAM controller decode.
// Contents: register addresses, status bit positions, TX/RX FSM state types.
package serial_mmio_uart_pkg;

  localparam logic [31:0] SERIAL_DATA_ADDR  = 32'hBFD0_03F8;
  localparam logic [31:0] SERIAL_STAT_ADDR  = 32'hBFD0_03FC;
  localparam int unsigned STAT_TX_READY_BIT = 0;
  localparam int unsigned STAT_RX_AVAIL_BIT = 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/serial_fifo.sv
// Synchronous FIFO, one per UART direction.
// Ports: clk, rst (sync, active-high), push/din, pop, head (entry at read
// pointer), full, empty. Pop when empty is ignored; push when full is dropped
// unless a pop happens on the same edge.
module serial_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/serial_mmio_uart.sv
// Memory-mapped 8N1 UART answering the CPU data port at SERIAL_DATA_ADDR
// (data) and SERIAL_STAT_ADDR (status: bit0 tx_ready, bit1 rx_avail).
// Ports: clk, rst (sync, active-high), mmio_addr_i/ce_i/we_n_i/data_i CPU
// access, mmio_data_o combinational read data, txd serial out, rxd serial in.
// Build option: SERIAL_LOOPBACK_EN feeds the RX synchroniser from txd and
// ignores the rxd pin.
module serial_mmio_uart
  import serial_mmio_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmio_addr_i,
  input  logic        mmio_ce_i,
  input  logic        mmio_we_n_i,
  input  logic [31:0] mmio_data_i,
  output logic [31:0] mmio_data_o,
  output logic        txd,
  input  logic        rxd
);

  localparam int unsigned DIV      = CLK_FREQ / BAUD;
  localparam int unsigned CW       = $clog2(DIV + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);

  logic       hit_dat, hit_st, rd_dat, wr_dat, rd_st;
  logic       tx_full, tx_empty, tx_pop;
  logic [7:0] tx_head;
  logic       rx_full, rx_empty, rx_push;
  logic [7:0] rx_head;
  logic       rx_in;
  logic       unused_ok;

  assign hit_dat = mmio_ce_i && (mmio_addr_i == SERIAL_DATA_ADDR);
  assign hit_st  = mmio_ce_i && (mmio_addr_i == SERIAL_STAT_ADDR);
  assign rd_dat  = hit_dat && mmio_we_n_i;
  assign wr_dat  = hit_dat && !mmio_we_n_i;
  assign rd_st   = hit_st && mmio_we_n_i;
  assign unused_ok = ^mmio_data_i[31:8] ^ rx_full;

`ifdef SERIAL_LOOPBACK_EN
  logic unused_rxd;
  assign rx_in      = txd;
  assign unused_rxd = rxd;
`else
  assign rx_in = rxd;
`endif

  always_comb begin
    mmio_data_o = '0;
    if (rd_st) begin
      mmio_data_o[STAT_TX_READY_BIT] = !tx_full;
      mmio_data_o[STAT_RX_AVAIL_BIT] = !rx_empty;
    end else if (rd_dat && !rx_empty) begin
      mmio_data_o = {24'b0, rx_head};
    end
  end

  serial_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(wr_dat), .din(mmio_data_i[7:0]), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  // ---------------- transmitter ----------------
  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          txd_n, tx_tick;

  assign tx_tick = (tx_cnt == BIT_END);

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: if (!tx_empty) begin
        tx_pop = 1'b1; tx_sh_n = tx_head; tx_state_n = TX_START;
      end
      TX_START: if (tx_tick) begin
        tx_state_n = TX_DATA; tx_bit_n = '0;
      end
      TX_DATA: if (tx_tick) begin
        tx_sh_n = tx_sh >> 1;
        if (tx_bit == 3'd7) tx_state_n = TX_STOP;
        else                tx_bit_n   = tx_bit + 1'b1;
      end
      TX_STOP: if (tx_tick) begin
        // Chain straight into the next start bit so frames stay back-to-back.
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_sh_n = tx_head; tx_state_n = TX_START;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
    endcase
    // txd is registered from the next state so it never glitches.
    case (tx_state_n)
      TX_START: txd_n = 1'b0;
      TX_DATA:  txd_n = tx_sh_n[0];
      default:  txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE; tx_cnt <= '0; tx_bit <= '0; tx_sh <= '0; txd <= 1'b1;
    end else begin
      tx_state <= tx_state_n; tx_cnt <= tx_cnt_n; tx_bit <= tx_bit_n;
      tx_sh <= tx_sh_n; txd <= txd_n;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic          rx_s1, rx_s2, rx_s3;

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_push    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_s3 && !rx_s2) rx_state_n = RX_START;
      end
      RX_START: if (rx_cnt == HALF_END) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_END) begin
        rx_cnt_n = '0;
        rx_sh_n  = {rx_s2, rx_sh[7:1]};
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        else                rx_bit_n   = rx_bit + 1'b1;
      end
      RX_STOP: if (rx_cnt == BIT_END) begin
        rx_cnt_n   = '0;
        rx_push    = rx_s2;
        rx_state_n = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_s3 <= 1'b1;
      rx_state <= RX_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
    end else begin
      rx_s1 <= rx_in; rx_s2 <= rx_s1; rx_s3 <= rx_s2;
      rx_state <= rx_state_n; rx_cnt <= rx_cnt_n; rx_bit <= rx_bit_n; rx_sh <= rx_sh_n;
    end
  end

  // A byte completing into a full FIFO is dropped inside the FIFO.
  serial_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din(rx_sh), .pop(rd_dat),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

endmodule
